// File: rtl/ids_bus_arbiter.sv
// ids_bus_arbiter
//   Two-master arbiter for the shared data-side bus. The core DMEM port and
//   the DMA port each request ownership. One master owns the bus at a time.
//   The owner's command is forwarded to the slave side. Read data, which
//   returns one cycle after the read strobe, is steered back to the master
//   that issued the read.
//   Ties go round-robin. A burst cap limits how long one master can keep the
//   bus while the other one is waiting.
// Ports
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_core_* / o_core_*            core master: req, gnt, addr, read, write,
//                                  size, wdata, rdata
//   i_dma_*  / o_dma_*             DMA master, same set
//   o_slv_addr/read/write/size/wdata  command forwarded from the owner
//   i_slv_rdata                    slave read data, valid the cycle after o_slv_read
module ids_bus_arbiter #(
   parameter int XLEN      = 32,
   parameter int MAX_BURST = 16
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_core_req,
   output logic            o_core_gnt,
   input  logic [XLEN-1:0] i_core_addr,
   input  logic            i_core_read,
   input  logic            i_core_write,
   input  logic [3:0]      i_core_size,
   input  logic [XLEN-1:0] i_core_wdata,
   output logic [XLEN-1:0] o_core_rdata,
   input  logic            i_dma_req,
   output logic            o_dma_gnt,
   input  logic [XLEN-1:0] i_dma_addr,
   input  logic            i_dma_read,
   input  logic            i_dma_write,
   input  logic [3:0]      i_dma_size,
   input  logic [XLEN-1:0] i_dma_wdata,
   output logic [XLEN-1:0] o_dma_rdata,
   output logic [XLEN-1:0] o_slv_addr,
   output logic            o_slv_read,
   output logic            o_slv_write,
   output logic [3:0]      o_slv_size,
   output logic [XLEN-1:0] o_slv_wdata,
   input  logic [XLEN-1:0] i_slv_rdata
);

   // The counter never needs to exceed MAX_BURST-1. Ownership moves as soon as it gets there.
   localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CW-1:0] CAP = CW'(MAX_BURST - 1);

   typedef enum logic [1:0] {S_IDLE, S_CORE, S_DMA} state_t;
   typedef enum logic [1:0] {RD_NONE, RD_CORE, RD_DMA} rd_own_t;

   state_t        state_q, state_d;
   rd_own_t       rd_owner_q, rd_owner_d;
   logic          last_dma_q, last_dma_d;   // 1: DMA owned last, so the core wins the next tie
   logic [CW-1:0] burst_cnt_q, burst_cnt_d;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= S_IDLE;
         rd_owner_q  <= RD_NONE;
         last_dma_q  <= 1'b1;
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         rd_owner_q  <= rd_owner_d;
         last_dma_q  <= last_dma_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   // Next state and burst bookkeeping
   always_comb begin
      state_d     = state_q;
      last_dma_d  = last_dma_q;
      burst_cnt_d = burst_cnt_q;
      case (state_q)
         S_IDLE: begin
            burst_cnt_d = '0;
            if (i_core_req && i_dma_req) state_d = last_dma_q ? S_CORE : S_DMA;
            else if (i_core_req)         state_d = S_CORE;
            else if (i_dma_req)          state_d = S_DMA;
         end
         S_CORE: begin
            if (!i_core_req)                     state_d = i_dma_req ? S_DMA : S_IDLE;
            else if (i_dma_req && burst_cnt_q == CAP) state_d = S_DMA;
            // The counter only runs while the other master is waiting.
            if (i_dma_req) burst_cnt_d = burst_cnt_q + CW'(1);
         end
         S_DMA: begin
            if (!i_dma_req)                       state_d = i_core_req ? S_CORE : S_IDLE;
            else if (i_core_req && burst_cnt_q == CAP) state_d = S_CORE;
            if (i_core_req) burst_cnt_d = burst_cnt_q + CW'(1);
         end
         default: state_d = S_IDLE;
      endcase
      if (state_d != state_q) begin
         burst_cnt_d = '0;
         if (state_q == S_CORE) last_dma_d = 1'b0;
         if (state_q == S_DMA)  last_dma_d = 1'b1;
      end
   end

   assign o_core_gnt = (state_q == S_CORE);
   assign o_dma_gnt  = (state_q == S_DMA);

   // Forward the owner's command. A master's strobes count only while it holds req.
   always_comb begin
      o_slv_addr  = '0;
      o_slv_read  = 1'b0;
      o_slv_write = 1'b0;
      o_slv_size  = '0;
      o_slv_wdata = '0;
      rd_owner_d  = RD_NONE;
      case (state_q)
         S_CORE: begin
            o_slv_addr  = i_core_addr;
            o_slv_read  = i_core_read & i_core_req;
            o_slv_write = i_core_write & i_core_req;
            o_slv_size  = i_core_size;
            o_slv_wdata = i_core_wdata;
            if (i_core_read && i_core_req) rd_owner_d = RD_CORE;
         end
         S_DMA: begin
            o_slv_addr  = i_dma_addr;
            o_slv_read  = i_dma_read & i_dma_req;
            o_slv_write = i_dma_write & i_dma_req;
            o_slv_size  = i_dma_size;
            o_slv_wdata = i_dma_wdata;
            if (i_dma_read && i_dma_req) rd_owner_d = RD_DMA;
         end
         default: ;
      endcase
   end

   // Return data follows the issuer of the read. It ignores the current grant,
   // so a read made just before a handover still reaches the master that made it.
   assign o_core_rdata = (rd_owner_q == RD_CORE) ? i_slv_rdata : '0;
   assign o_dma_rdata  = (rd_owner_q == RD_DMA)  ? i_slv_rdata : '0;

endmodule

// File: tb/tb_ids_bus_arbiter.sv
module tb_ids_bus_arbiter;

   localparam logic [31:0] CADDR = 32'h1000_0004;
   localparam logic [31:0] DADDR = 32'h2000_0000;
   localparam logic [31:0] CWD   = 32'hC0DE_0001;
   localparam logic [31:0] DWD   = 32'hD0DE_0002;
   localparam logic [3:0]  CSZ   = 4'hF;
   localparam logic [3:0]  DSZ   = 4'h3;

   logic        clk, rst_n;
   logic        core_req, core_read, core_write, dma_req, dma_read, dma_write;
   logic        core_gnt, dma_gnt, slv_read, slv_write;
   logic [31:0] core_rdata, dma_rdata, slv_addr, slv_wdata, slv_rdata;
   logic [3:0]  slv_size;

   int checks = 0;
   int errors = 0;

   ids_bus_arbiter #(.XLEN(32), .MAX_BURST(4)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_core_req(core_req), .o_core_gnt(core_gnt), .i_core_addr(CADDR),
      .i_core_read(core_read), .i_core_write(core_write), .i_core_size(CSZ),
      .i_core_wdata(CWD), .o_core_rdata(core_rdata),
      .i_dma_req(dma_req), .o_dma_gnt(dma_gnt), .i_dma_addr(DADDR),
      .i_dma_read(dma_read), .i_dma_write(dma_write), .i_dma_size(DSZ),
      .i_dma_wdata(DWD), .o_dma_rdata(dma_rdata),
      .o_slv_addr(slv_addr), .o_slv_read(slv_read), .o_slv_write(slv_write),
      .o_slv_size(slv_size), .o_slv_wdata(slv_wdata), .i_slv_rdata(slv_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        cr, crd, cw, dr, drd, dw;
      logic [31:0] rdata;
      logic        cg, dg, sr, sw;
      logic [31:0] crdat, drdat;
   } vec_t;

   vec_t vec [13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic cr, crd, cw, dr, drd, dw, input logic [31:0] rd);
      core_req = cr; core_read = crd; core_write = cw;
      dma_req = dr; dma_read = drd; dma_write = dw;
      slv_rdata = rd;
   endtask

   // Inputs change just after a rising edge. Outputs are sampled on the falling edge.
   task automatic step(input logic cr, crd, cw, dr, drd, dw, input logic [31:0] rd);
      @(posedge clk);
      #1;
      set_in(cr, crd, cw, dr, drd, dw, rd);
      #4;
   endtask

   initial begin
      logic [31:0] ea, ewd;
      logic [3:0]  esz;
      //            cr crd cw dr drd dw rdata          cg dg sr sw crdat          drdat
      vec[0]  = '{0, 0, 0, 0, 0, 0, 32'hAAAA_AAAA, 0, 0, 0, 0, 32'h0,          32'h0};
      vec[1]  = '{1, 1, 1, 1, 0, 0, 32'h0000_0001, 0, 0, 0, 0, 32'h0,          32'h0};
      vec[2]  = '{1, 1, 1, 1, 0, 0, 32'h0000_0002, 1, 0, 1, 1, 32'h0,          32'h0};
      vec[3]  = '{0, 0, 0, 0, 0, 0, 32'h1234_5678, 1, 0, 0, 0, 32'h1234_5678, 32'h0};
      vec[4]  = '{1, 0, 0, 1, 1, 1, 32'h0000_0009, 0, 0, 0, 0, 32'h0,          32'h0};
      vec[5]  = '{1, 0, 0, 1, 1, 1, 32'h0000_0005, 0, 1, 1, 1, 32'h0,          32'h0};
      vec[6]  = '{1, 0, 0, 1, 1, 0, 32'h0000_0066, 0, 1, 1, 0, 32'h0,          32'h66};
      vec[7]  = '{1, 0, 0, 1, 1, 0, 32'h0000_0077, 0, 1, 1, 0, 32'h0,          32'h77};
      vec[8]  = '{1, 0, 0, 1, 1, 0, 32'h0000_0088, 0, 1, 1, 0, 32'h0,          32'h88};
      vec[9]  = '{1, 0, 1, 1, 1, 0, 32'h0000_0099, 1, 0, 0, 1, 32'h0,          32'h99};
      vec[10] = '{0, 0, 0, 1, 1, 0, 32'h0000_00AA, 1, 0, 0, 0, 32'h0,          32'h0};
      vec[11] = '{0, 0, 0, 0, 1, 1, 32'h0000_00BB, 0, 1, 0, 0, 32'h0,          32'h0};
      vec[12] = '{0, 0, 0, 0, 0, 0, 32'h0000_00CC, 0, 0, 0, 0, 32'h0,          32'h0};

      rst_n = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 32'h0);
      #22;
      rst_n = 1'b1;

      // Table: covers reset state, the first tie (core wins), the second tie
      // (DMA wins), the burst cap and read routing across a handover.
      for (int i = 0; i < 13; i++) begin
         step(vec[i].cr, vec[i].crd, vec[i].cw, vec[i].dr, vec[i].drd, vec[i].dw, vec[i].rdata);
         ea  = vec[i].cg ? CADDR : (vec[i].dg ? DADDR : 32'h0);
         ewd = vec[i].cg ? CWD   : (vec[i].dg ? DWD   : 32'h0);
         esz = vec[i].cg ? CSZ   : (vec[i].dg ? DSZ   : 4'h0);
         chk($sformatf("row%0d core_gnt", i),   {31'b0, core_gnt},  {31'b0, vec[i].cg});
         chk($sformatf("row%0d dma_gnt", i),    {31'b0, dma_gnt},   {31'b0, vec[i].dg});
         chk($sformatf("row%0d slv_read", i),   {31'b0, slv_read},  {31'b0, vec[i].sr});
         chk($sformatf("row%0d slv_write", i),  {31'b0, slv_write}, {31'b0, vec[i].sw});
         chk($sformatf("row%0d slv_addr", i),   slv_addr,  ea);
         chk($sformatf("row%0d slv_wdata", i),  slv_wdata, ewd);
         chk($sformatf("row%0d slv_size", i),   {28'b0, slv_size}, {28'b0, esz});
         chk($sformatf("row%0d core_rdata", i), core_rdata, vec[i].crdat);
         chk($sformatf("row%0d dma_rdata", i),  dma_rdata,  vec[i].drdat);
      end

      // Uncontended DMA ownership: the grant holds for 64+ cycles.
      step(0, 0, 0, 1, 0, 0, 32'h0);
      chk("uncont_idle_first", {31'b0, dma_gnt}, 32'h0);
      for (int i = 0; i < 64; i++) begin
         step(0, 0, 0, 1, 0, 0, 32'h0);
         chk($sformatf("uncont_dma_gnt%0d", i), {30'b0, core_gnt, dma_gnt}, 32'h1);
      end
      // The counter did not advance while uncontended, so the core still waits the full 4 cycles.
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 0, 1, 0, 0, 32'h0);
         chk($sformatf("cap_after_uncont_dma%0d", i), {30'b0, core_gnt, dma_gnt}, 32'h1);
      end
      step(1, 0, 0, 1, 0, 0, 32'h0);
      chk("cap_after_uncont_core", {30'b0, core_gnt, dma_gnt}, 32'h2);

      // Asynchronous reset while the DMA owns the bus with a read in flight.
      step(0, 0, 0, 1, 1, 0, 32'h0);
      chk("pre_rst_core_still", {30'b0, core_gnt, dma_gnt}, 32'h2);
      step(0, 0, 0, 1, 1, 0, 32'h0000_0042);
      chk("pre_rst_dma_owns", {30'b0, core_gnt, dma_gnt}, 32'h1);
      step(0, 0, 0, 1, 1, 0, 32'h0000_0043);
      chk("pre_rst_dma_rdata", dma_rdata, 32'h0000_0043);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_gnts", {30'b0, core_gnt, dma_gnt}, 32'h0);
      chk("rst_slv_read", {31'b0, slv_read}, 32'h0);
      chk("rst_dma_rdata", dma_rdata, 32'h0);
      chk("rst_slv_addr", slv_addr, 32'h0);
      set_in(0, 0, 0, 0, 0, 0, 32'h0000_0044);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      step(0, 0, 0, 0, 0, 0, 32'h0);
      chk("post_rst_idle", {30'b0, core_gnt, dma_gnt}, 32'h0);
      step(1, 0, 0, 1, 0, 0, 32'h0);
      chk("post_rst_req_wait", {30'b0, core_gnt, dma_gnt}, 32'h0);
      step(1, 0, 0, 1, 0, 0, 32'h0);
      chk("post_rst_tie_core", {30'b0, core_gnt, dma_gnt}, 32'h2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
